// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache, 16 sets of 2-word blocks
// A miss fetches both words of the block from the memory controller, then serves the hit from IDLE.
module icache (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iflush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [15:0] hitcnt,
  output logic [15:0] misscnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH0 = 2'd1;
  localparam logic [1:0] FETCH1 = 2'd2;

  logic [1:0]  state, next_state;
  logic [15:0] valid;
  logic [24:0] tags   [16];
  logic [31:0] word0s [16];
  logic [31:0] word1s [16];
  logic [28:0] missaddr;
  logic [31:0] word0buf;

  logic [24:0] reqtag;
  logic [3:0]  reqidx;
  logic        reqoff;
  logic        miss;
  logic        fill_done;
  logic [1:0]  unused_bytesel;

  assign reqtag         = imemaddr[31:7];
  assign reqidx         = imemaddr[6:3];
  assign reqoff         = imemaddr[2];
  assign unused_bytesel = imemaddr[1:0];

  // No hit bypass while filling: lookups only happen in IDLE.
  assign ihit      = (state == IDLE) & imemREN & valid[reqidx] & (tags[reqidx] == reqtag);
  assign imemload  = ihit ? (reqoff ? word1s[reqidx] : word0s[reqidx]) : 32'h0;
  assign miss      = (state == IDLE) & imemREN & ~ihit;
  assign fill_done = (state == FETCH1) & ~iwait;
  assign iREN      = (state == FETCH0) | (state == FETCH1);

  always_comb begin
    iaddr = 32'h0;
    case (state)
      FETCH0:  iaddr = {missaddr, 3'b000};
      FETCH1:  iaddr = {missaddr, 3'b100};
      default: iaddr = 32'h0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (miss)   next_state = FETCH0;
      FETCH0:  if (!iwait) next_state = FETCH1;
      FETCH1:  if (!iwait) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      valid    <= '0;
      hitcnt   <= '0;
      misscnt  <= '0;
      missaddr <= '0;
      word0buf <= '0;
    end else begin
      state <= next_state;
      // Flush wins over a fill completing in the same cycle.
      if (iflush)
        valid <= '0;
      else if (fill_done)
        valid[missaddr[3:0]] <= 1'b1;
      if (ihit && hitcnt != 16'hFFFF)
        hitcnt <= hitcnt + 16'd1;
      if (miss && misscnt != 16'hFFFF)
        misscnt <= misscnt + 16'd1;
      if (miss)
        missaddr <= imemaddr[31:3];
      if (state == FETCH0 && !iwait)
        word0buf <= iload;
    end
  end

  // Tag and data arrays carry no reset; valid bits alone gate their use.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tags[missaddr[3:0]]   <= missaddr[28:4];
      word0s[missaddr[3:0]] <= word0buf;
      word1s[missaddr[3:0]] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized self-checking bench for icache
// Reference model tracks per-set valid/tag; data comes from a fixed memory function.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iflush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [15:0] hitcnt;
  logic [15:0] misscnt;

  icache dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iflush(iflush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload), .hitcnt(hitcnt), .misscnt(misscnt)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  bit          m_valid [16];
  logic [24:0] m_tag   [16];
  int          exp_hit;
  int          exp_miss;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h40) return 32'hAAAA0001;
    if (a == 32'h44) return 32'hAAAA0002;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk_cnt;
    check("hitcnt", {16'h0, hitcnt}, exp_hit);
    check("misscnt", {16'h0, misscnt}, exp_miss);
  endtask

  task automatic model_clear;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // mode: 0 normal, 1 drop request in FETCH0, 2 flush on final fill cycle, 3 reset in FETCH1.
  // Called just after a falling edge; returns just after a falling edge.
  task automatic access(input logic [31:0] a, input int w0, input int w1, input int mode);
    int          idx;
    int          w;
    bit          hit;
    logic [31:0] base;
    idx  = int'(a[6:3]);
    base = a & ~32'h7;
    imemREN = 1'b1; imemaddr = a; iwait = 1'b1; iflush = 1'b0;
    #1;
    hit = m_valid[idx] && (m_tag[idx] == a[31:7]);
    check("ihit_lookup", {31'h0, ihit}, {31'h0, hit});
    check("iREN_idle", {31'h0, iREN}, 32'h0);
    if (hit) begin
      check("imemload_hit", imemload, mem(a & ~32'h3));
      @(posedge CLK); exp_hit = sat(exp_hit + 1); @(negedge CLK);
      chk_cnt;
      return;
    end
    check("imemload_miss", imemload, 32'h0);
    @(posedge CLK); exp_miss = sat(exp_miss + 1); @(negedge CLK);
    if (mode == 1) begin imemREN = 1'b0; imemaddr = $urandom; end
    for (int p = 0; p < 2; p++) begin
      w = (p == 1) ? w1 : w0;
      for (int c = 0; c <= w; c++) begin
        if (mode == 3 && p == 1) begin
          iwait = 1'b1; nRST = 1'b0;
          #1;
          exp_hit = 0; exp_miss = 0; model_clear();
          check("rst_iREN", {31'h0, iREN}, 32'h0);
          check("rst_iaddr", iaddr, 32'h0);
          check("rst_ihit", {31'h0, ihit}, 32'h0);
          check("rst_imemload", imemload, 32'h0);
          chk_cnt;
          @(posedge CLK); @(negedge CLK);
          nRST = 1'b1; imemREN = 1'b0;
          return;
        end
        iwait = (c < w);
        iload = (c < w) ? $urandom : mem(base + 32'(4 * p));
        if (mode == 2 && p == 1 && c == w) iflush = 1'b1;
        #1;
        check("iREN_fill", {31'h0, iREN}, 32'h1);
        check("iaddr_fill", iaddr, base + 32'(4 * p));
        check("ihit_fill", {31'h0, ihit}, 32'h0);
        @(posedge CLK); @(negedge CLK);
      end
    end
    iflush = 1'b0; iwait = 1'b1;
    if (mode == 2) model_clear();
    else begin m_valid[idx] = 1'b1; m_tag[idx] = a[31:7]; end
    if (mode != 0) imemREN = 1'b0;
    #1;
    hit = imemREN && m_valid[idx] && (m_tag[idx] == a[31:7]);
    check("ihit_after_fill", {31'h0, ihit}, {31'h0, hit});
    check("iREN_after_fill", {31'h0, iREN}, 32'h0);
    check("iaddr_after_fill", iaddr, 32'h0);
    if (hit) begin
      check("imemload_after_fill", imemload, mem(a & ~32'h3));
      @(posedge CLK); exp_hit = sat(exp_hit + 1); @(negedge CLK);
    end
    chk_cnt;
  endtask

  task automatic flush_pulse;
    imemREN = 1'b0; iflush = 1'b1;
    @(posedge CLK); @(negedge CLK);
    iflush = 1'b0; model_clear();
    #1;
    check("iREN_flush", {31'h0, iREN}, 32'h0);
    chk_cnt;
  endtask

  logic [31:0] ra;
  int          rmode;

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0; iwait = 1'b1; iload = '0;
    exp_hit = 0; exp_miss = 0; model_clear();
    #1;
    check("reset_iREN", {31'h0, iREN}, 32'h0);
    check("reset_iaddr", iaddr, 32'h0);
    check("reset_ihit", {31'h0, ihit}, 32'h0);
    check("reset_imemload", imemload, 32'h0);
    chk_cnt;
    @(negedge CLK); @(negedge CLK);
    nRST = 1'b1;

    // Cold miss, then conflict eviction on index 8.
    access(32'h44, 0, 0, 0);
    check("cold_misscnt", {16'h0, misscnt}, 32'd1);
    check("cold_hitcnt", {16'h0, hitcnt}, 32'd1);
    access(32'h40, 0, 0, 0);
    access(32'hC0, 0, 0, 0);
    access(32'h40, 0, 0, 0);
    check("evict_misscnt", {16'h0, misscnt}, 32'd3);

    // Stretched memory, abandoned request, flushes.
    access(32'h104, 5, 5, 0);
    access(32'h100, 0, 0, 0);
    access(32'h208, 0, 1, 1);
    access(32'h20C, 0, 0, 0);
    access(32'h300, 0, 0, 0);
    access(32'h310, 1, 0, 0);
    access(32'h320, 0, 2, 0);
    flush_pulse();
    access(32'h300, 0, 0, 0);
    access(32'h314, 0, 0, 0);
    access(32'h400, 1, 1, 2);
    access(32'h400, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      ra = (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 3)) << 7)
         | (32'($urandom_range(0, 15)) << 3) | 32'($urandom_range(0, 7));
      rmode = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      access(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rmode);
      if ($urandom_range(0, 30) == 0) flush_pulse();
    end

    // Reset mid-fill abandons the block.
    access(32'h500, 0, 2, 3);
    access(32'h500, 0, 0, 0);
    check("postreset_misscnt", {16'h0, misscnt}, 32'd1);

    // Hit counter saturation.
    imemREN = 1'b1; imemaddr = 32'h504;
    for (int i = 0; i < 70000; i++) begin
      @(posedge CLK); exp_hit = sat(exp_hit + 1);
    end
    @(negedge CLK);
    check("hitcnt_sat", {16'h0, hitcnt}, 32'h0000FFFF);
    chk_cnt;
    imemREN = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
